mux_scan_nx1: RTL and testbench

//  Parametrised N-input, W-bit registered multiplexer; generalises the fixed 4x1 single-bit mux.
//  Two modes: MANUAL (external select) and SCAN (internal round-robin sweep of all channels,

---
 rtl/mux_pkg.sv | 17 +
 rtl/mux_dwell_counter.sv | 39 +++
 rtl/mux_scan_nx1.sv | 124 ++++++++++++
 tb/tb_mux_scan_nx1.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the scanning N:1 registered multiplexer.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    // A dwell of one cycle still needs a 1-bit counter register.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mux_dwell_counter.sv
// Modulo-DWELL counter; tc flags the last count of the dwell period.
module mux_dwell_counter
    import mux_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int unsigned       CNT_W = cnt_width(DWELL);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_nx1.sv
// N-input, W-bit registered multiplexer with manual select or round-robin scan,
// each scanned channel held for DWELL cycles.
module mux_scan_nx1
    import mux_pkg::*;
#(
    parameter  int unsigned N     = 4,
    parameter  int unsigned W     = 1,
    parameter  int unsigned DWELL = 4,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*W-1:0]     in_data,
    input  logic [SEL_W-1:0]   select,
    input  logic               mode,
    input  logic               enable,
    output logic [W-1:0]       out,
    output logic               out_valid,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               scan_wrap
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N - 1);
    localparam logic [SEL_W:0]   N_EXT   = (SEL_W + 1)'(N);

    state_t             state_q;
    state_t             state_d;
    logic [SEL_W-1:0]   cur_sel_q;
    logic [SEL_W-1:0]   cur_sel_d;
    logic [W-1:0]       out_q;
    logic [W-1:0]       out_d;
    logic               valid_q;
    logic               valid_d;
    logic               wrap_q;
    logic               wrap_d;

    logic               scan_run;
    logic               tc;
    logic               sel_legal;
    logic [W-1:0]       sel_data;

    // Only an uninterrupted SCAN cycle advances the dwell; any other enabled
    // cycle (manual, or the first scan cycle) restarts it.
    assign scan_run = enable && (state_q == ST_SCAN) && (mode == MODE_SCAN);

    mux_dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (scan_run),
        .clr   (enable && !scan_run),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_MANUAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (enable) begin
            state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
        end
    end

    // An out-of-range index left over from manual mode wraps to channel 0 on its first advance.
    always_comb begin
        cur_sel_d = cur_sel_q;
        wrap_d    = 1'b0;
        if (enable) begin
            if (!scan_run) begin
                cur_sel_d = select;
            end else if (tc) begin
                cur_sel_d = (cur_sel_q >= LAST_CH) ? '0 : cur_sel_q + SEL_W'(1);
                wrap_d    = (cur_sel_q == LAST_CH);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (cur_sel_d == SEL_W'(k)) begin
                sel_data = in_data[k*W +: W];
            end
        end
    end

    assign sel_legal = ({1'b0, cur_sel_d} < N_EXT);

    always_comb begin
        out_d   = '0;
        valid_d = 1'b0;
        if (enable && sel_legal) begin
            out_d   = sel_data;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_sel_q <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            cur_sel_q <= cur_sel_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign cur_sel   = cur_sel_q;
    assign scan_wrap = wrap_q;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Bench for mux_scan_nx1: instance A (N=4, W=8, DWELL=3) and instance B (N=5, W=8, DWELL=1).
module tb_mux_scan_nx1;

    logic        clk;
    logic        rst_n;

    logic [31:0] in_a;
    logic [1:0]  sel_a;
    logic        mode_a;
    logic        en_a;
    logic [7:0]  out_a;
    logic        v_a;
    logic [1:0]  cs_a;
    logic        wr_a;

    logic [39:0] in_b;
    logic [2:0]  sel_b;
    logic        mode_b;
    logic        en_b;
    logic [7:0]  out_b;
    logic        v_b;
    logic [2:0]  cs_b;
    logic        wr_b;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int         m_sel  [2];
    int         m_age  [2];
    bit         m_scan [2];
    logic [7:0] e_out  [2];
    logic       e_val  [2];
    logic       e_wrap [2];

    mux_scan_nx1 #(.N(4), .W(8), .DWELL(3)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_a),
        .select    (sel_a),
        .mode      (mode_a),
        .enable    (en_a),
        .out       (out_a),
        .out_valid (v_a),
        .cur_sel   (cs_a),
        .scan_wrap (wr_a)
    );

    mux_scan_nx1 #(.N(5), .W(8), .DWELL(1)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_b),
        .select    (sel_b),
        .mode      (mode_b),
        .enable    (en_b),
        .out       (out_b),
        .out_valid (v_b),
        .cur_sel   (cs_b),
        .scan_wrap (wr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sel[i]  = 0;
            m_age[i]  = 0;
            m_scan[i] = 1'b0;
            e_out[i]  = 8'h00;
            e_val[i]  = 1'b0;
            e_wrap[i] = 1'b0;
        end
    endtask

    // Behavioural model: age counts cycles spent on the current channel.
    task automatic step(input int i, input int n, input int d, input bit en, input bit md,
                        input int sel, input logic [39:0] data);
        if (!en) begin
            e_out[i]  = 8'h00;
            e_val[i]  = 1'b0;
            e_wrap[i] = 1'b0;
            return;
        end
        e_wrap[i] = 1'b0;
        if (md && m_scan[i]) begin
            m_age[i]++;
            if (m_age[i] == d) begin
                m_age[i] = 0;
                if (m_sel[i] == n - 1) e_wrap[i] = 1'b1;
                m_sel[i] = (m_sel[i] >= n - 1) ? 0 : m_sel[i] + 1;
            end
        end else begin
            m_sel[i]  = sel;
            m_age[i]  = 0;
            m_scan[i] = md;
        end
        e_val[i] = (m_sel[i] < n);
        e_out[i] = e_val[i] ? 8'(data >> (m_sel[i] * 8)) : 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            step(0, 4, 3, en_a, mode_a, int'(sel_a), {8'h00, in_a});
            step(1, 5, 1, en_b, mode_b, int'(sel_b), in_b);
        end
        #1;
        chk("a_out",  32'(out_a), 32'(e_out[0]));
        chk("a_val",  32'(v_a),   32'(e_val[0]));
        chk("a_sel",  32'(cs_a),  32'(m_sel[0]));
        chk("a_wrap", 32'(wr_a),  32'(e_wrap[0]));
        chk("b_out",  32'(out_b), 32'(e_out[1]));
        chk("b_val",  32'(v_b),   32'(e_val[1]));
        chk("b_sel",  32'(cs_b),  32'(m_sel[1]));
        chk("b_wrap", 32'(wr_b),  32'(e_wrap[1]));
    endtask

    initial begin
        int exp_seq [10] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

        rst_n  = 1'b1;
        in_a   = 32'hDDCC_BBAA;
        sel_a  = 2'd3;
        mode_a = 1'b1;
        en_a   = 1'b1;
        in_b   = 40'h55_4433_2211;
        sel_b  = 3'd0;
        mode_b = 1'b1;
        en_b   = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);

        // Async reset between edges, scan mode requested
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_out",   32'(out_a), 32'h0);
        chk("rst_valid", 32'(v_a),   32'h0);
        chk("rst_sel",   32'(cs_a),  32'h0);
        chk("rst_wrap",  32'(wr_a),  32'h0);
        chk("rst_b_val", 32'(v_b),   32'h0);
        tick();
        @(negedge clk) rst_n = 1'b1;

        // Manual select of channel 2
        mode_a = 1'b0;
        sel_a  = 2'd2;
        tick();
        chk("man_out",   32'(out_a), 32'hCC);
        chk("man_valid", 32'(v_a),   32'h1);
        chk("man_sel",   32'(cs_a),  32'h2);

        // Scan from channel 1, dwell 3
        sel_a  = 2'd1;
        mode_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("scan_seq",  32'(cs_a), 32'(exp_seq[i]));
            chk("scan_wrap", 32'(wr_a), (i == 9) ? 32'h1 : 32'h0);
        end
        repeat (7) tick();
        chk("pre_dis_sel", 32'(cs_a), 32'h2);

        // Disable mid-dwell, then resume
        en_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("dis_out",   32'(out_a), 32'h0);
            chk("dis_valid", 32'(v_a),   32'h0);
            chk("dis_sel",   32'(cs_a),  32'h2);
        end
        en_a = 1'b1;
        tick();
        chk("resume_sel", 32'(cs_a),  32'h2);
        chk("resume_out", 32'(out_a), 32'hCC);
        tick();
        chk("resume_adv", 32'(cs_a),  32'h3);
        chk("resume_dd",  32'(out_a), 32'hDD);

        // Mode drop coinciding with dwell expiry
        repeat (2) tick();
        mode_a = 1'b0;
        sel_a  = 2'd1;
        tick();
        chk("expiry_sel", 32'(cs_a),  32'h1);
        chk("expiry_out", 32'(out_a), 32'hBB);

        // N=5: illegal then legal select
        mode_b = 1'b0;
        sel_b  = 3'd6;
        tick();
        chk("ill_out",   32'(out_b), 32'h0);
        chk("ill_valid", 32'(v_b),   32'h0);
        chk("ill_sel",   32'(cs_b),  32'h6);
        sel_b = 3'd4;
        tick();
        chk("ch4_out",   32'(out_b), 32'h55);
        chk("ch4_valid", 32'(v_b),   32'h1);

        // Reset in the middle of a scan, restart from select
        mode_a = 1'b1;
        sel_a  = 2'd0;
        repeat (10) tick();
        chk("pre_rst_sel", 32'(cs_a), 32'h3);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_out",   32'(out_a), 32'h0);
        chk("mid_rst_valid", 32'(v_a),   32'h0);
        chk("mid_rst_sel",   32'(cs_a),  32'h0);
        sel_a = 2'd2;
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("restart_sel", 32'(cs_a),  32'h2);
        chk("restart_out", 32'(out_a), 32'hCC);
        repeat (3) tick();
        chk("restart_adv", 32'(cs_a),  32'h3);

        // Randomized traffic on both instances
        for (int i = 0; i < 400; i++) begin
            en_a  = (($urandom % 8) != 0);
            en_b  = (($urandom % 8) != 0);
            if (($urandom % 10) == 0) mode_a = ~mode_a;
            if (($urandom % 10) == 0) mode_b = ~mode_b;
            sel_a = 2'($urandom);
            sel_b = 3'($urandom);
            in_a  = $urandom;
            in_b  = {8'($urandom), $urandom};
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
